audio_adc_rx: RTL
=================

// Module: audio_adc_rx
// PURPOSE
//  Receive side of the WM8731 codec serial audio link: deserializes AUD_ADCDAT (I2S) into stereo frames.
//  Complements the DAC transmit path that drives AUD_DACDAT from the mixer.
//  BCLK/ADCLRCK are sampled as data in the CLOCK_50 domain; frames are buffered in a small FIFO.
//  Frames are handed out on a valid/ready interface for a future record/trigger path.
// PARAMETERS
//  SAMPLE_BITS  16  bits per channel; frame = {left,right}, 2*SAMPLE_BITS wide
//  FIFO_DEPTH   4   frames buffered, power of two, >=2
// PORTS
//  clk            in   1      CLOCK_50; sole clock
//  reset          in   1      synchronous, active-high
//  enable         in   1      capture enable (tied to play)
//  aud_bclk       in   1      codec bit clock, async; freq <= clk/4
//  aud_adclrck    in   1      codec ADC LR clock, async; 0 = left, 1 = right
//  aud_adcdat     in   1      codec ADC serial data, async
//  sample_data    out  2*SB   {left,right}, MSB-first per channel; head of FIFO
//  sample_valid   out  1      FIFO not empty
//  sample_ready   in   1      consumer accepts; pop when valid&&ready
//  fifo_level     out  clog2(FIFO_DEPTH)+1  frames stored
//  overflow       out  1      sticky: a completed frame was dropped
//  overflow_clr   in   1      clears overflow (set wins if same cycle)
// BEHAVIOUR
//  Reset: sample_data=0, sample_valid=0, fifo_level=0, overflow=0, FSM=ALIGN, shift regs/counters 0.
//  Input conditioning: bclk, lrck, adcdat each pass a 2-flop synchronizer, then 1 history flop.
//   bclk_rise/lrck_rise/lrck_fall are 1-cycle pulses; pin edge -> pulse in 3 clk cycles.
//   adcdat is delayed identically, so the captured bit is the value at the BCLK rising edge.
//  FSM ALIGN/LEFT/RIGHT:
//   ALIGN: wait for lrck_fall -> LEFT. Partial frames at start-up are never emitted.
//   LEFT: on lrck_rise -> RIGHT; left shift reg copied to left_hold.
//   RIGHT: on lrck_fall -> LEFT; push {left_hold,right_sr}.
//   enable=0 (any cycle): -> ALIGN; in-progress frame discarded; FIFO kept and drainable.
//  Bit capture per channel: on each LRCK edge, bit_cnt=0 and channel shift reg=0.
//   On bclk_rise: bit_cnt==0 -> I2S delay slot, ignored.
//   bit_cnt 1..SB -> bit stored at index SB-bit_cnt.
//   bit_cnt saturates at SB+1; extra bits are ignored.
//   Short words (<SB bits) are therefore left-justified and zero-padded.
//  Push on lrck_fall cycle in RIGHT. Frame is visible at sample_data/sample_valid the next cycle.
//   Total latency: pin LRCK fall -> sample_valid = 4 clk.
//  Push when full: accepted if a pop occurs in the same cycle.
//   Otherwise the new frame is dropped, FIFO unchanged, overflow=1 next cycle.
//  Push+pop when empty: frame is written; valid rises next cycle (no fall-through).
//  sample_data is registered from the FIFO head; holds its value while valid && !ready.
//  Pointers wrap modulo FIFO_DEPTH; fifo_level is a separate counter (+1 push, -1 pop, 0 both).
// STRUCTURE
//  Shared include audio_defs.vh: SAMPLE_BITS default, FSM state localparams, LRCK polarity constants.
//  One sub-module, sync_fifo (WIDTH, DEPTH): push/pop/full/empty/level, registered head.
//   Reusable for the mixer-to-DAC path.
//  Top holds the synchronizers, edge detect, FSM, bit counter and shift regs.
// TESTING (SB=16, DEPTH=4, BCLK period 16 clk, LRCK = 32 BCLK per frame)
//  1 Frame L=16'hA5C3, R=16'h1234, ready=1 -> sample_data=32'hA5C31234, valid 1 cycle, 4 clk after LRCK fall.
//  2 ready=0; send 5 frames (L=n, R=~n, n=1..5) -> level=4, overflow=1.
//     Then drain: frames 1..4 in order; frame 5 absent.
//  3 Start codec mid-right-channel; send L=16'h0F0F, R=16'hF0F0 -> only the first complete frame emitted.
//  4 12-bit words L=12'hABC, R=12'h123 -> 32'hABC01230.
//    20-bit words -> low 4 bits dropped.
//  5 enable low mid-LEFT, high again -> that frame is dropped; next full frame captured correctly.
//  6 FIFO full, ready=1 on the push cycle -> push accepted, level stays 4, overflow=0.
//    Then reset mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/audio_adc_rx_pkg.sv
// Shared constants and types for the codec ADC receive path.
// Sample width and FIFO depth defaults, LRCK channel polarity, FSM states.
package audio_adc_rx_pkg;

  localparam int SAMPLE_BITS_DEF = 16;
  localparam int FIFO_DEPTH_DEF  = 4;

  // ADCLRCK level that selects each channel
  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_ALIGN,
    ST_LEFT,
    ST_RIGHT
  } rx_state_t;

endpackage

// File: rtl/audio_adc_rx_if.sv
// Stereo frame stream plus FIFO status between the ADC receiver and its consumer.
// master = receiver (drives frames and status), slave = consumer (drives ready and clear).
interface audio_adc_rx_if
  import audio_adc_rx_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) ();

  logic [2*SAMPLE_BITS-1:0]     sample_data;
  logic                         sample_valid;
  logic                         sample_ready;
  logic [$clog2(FIFO_DEPTH):0]  fifo_level;
  logic                         overflow;
  logic                         overflow_clr;

  modport master (
    output sample_data, sample_valid, fifo_level, overflow,
    input  sample_ready, overflow_clr
  );

  modport slave (
    input  sample_data, sample_valid, fifo_level, overflow,
    output sample_ready, overflow_clr
  );

endinterface

// File: rtl/audio_adc_rx_fifo.sv
// sync_fifo: small single-clock FIFO with a registered head word.
// Latency: a pushed word appears on head_dat/valid the cycle after the push (no fall-through).
// Backpressure: push when full succeeds only alongside a pop; otherwise dropped is pulsed.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     valid,
  output logic                     dropped,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_next;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign valid   = (level_q != '0);
  assign full    = (level_q == LW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign level   = level_q;

  // Next read pointer and occupancy; simultaneous push and pop leave the level unchanged
  always_comb begin
    rd_next    = rd_ptr;
    level_next = level_q;
    if (do_pop) begin
      rd_next = rd_ptr + AW'(1);
    end
    if (do_push && !do_pop) begin
      level_next = level_q + LW'(1);
    end else if (!do_push && do_pop) begin
      level_next = level_q - LW'(1);
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers, level and registered head; a word written into the next head slot is forwarded
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      head_dat <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_next;
      level_q <= level_next;
      if (level_next == '0) begin
        head_dat <= '0;
      end else if (do_push && (wr_ptr == rd_next)) begin
        head_dat <= push_dat;
      end else begin
        head_dat <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/audio_adc_rx.sv
// audio_adc_rx: deserializes WM8731 I2S ADC data into {left,right} frames on a valid/ready stream.
// Latency: pin ADCLRCK fall -> sample_valid 4 clk (2 sync flops, history flop, registered push).
// Backpressure: FIFO_DEPTH frames buffered; a frame completing into a full FIFO is dropped, sticky overflow.
module audio_adc_rx
  import audio_adc_rx_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            aud_bclk,
  input  logic            aud_adclrck,
  input  logic            aud_adcdat,
  audio_adc_rx_if.master  rx
);

  localparam int CNT_W = $clog2(SAMPLE_BITS + 2);
  localparam int IDX_W = $clog2(SAMPLE_BITS);
  localparam logic [CNT_W-1:0] CNT_SB  = CNT_W'(SAMPLE_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_BITS + 1);

  // [0],[1] synchronizer, [2] history
  logic [2:0] bclk_sync;
  logic [2:0] lrck_sync;
  logic [2:0] dat_sync;

  logic bclk_rise;
  logic lrck_rise;
  logic lrck_fall;
  logic dat_bit;

  rx_state_t                  state;
  logic [CNT_W-1:0]           bit_cnt;
  logic [IDX_W-1:0]           bit_idx;
  logic                       bit_take;
  logic [SAMPLE_BITS-1:0]     left_sr;
  logic [SAMPLE_BITS-1:0]     right_sr;
  logic [SAMPLE_BITS-1:0]     left_hold;
  logic                       push_vld;
  logic [2*SAMPLE_BITS-1:0]   push_dat;
  logic                       fifo_drop;

  // Bring the async codec pins into the clk domain and keep one cycle of history
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], aud_bclk};
      lrck_sync <= {lrck_sync[1:0], aud_adclrck};
      dat_sync  <= {dat_sync[1:0], aud_adcdat};
    end
  end

  assign bclk_rise = bclk_sync[1] && !bclk_sync[2];
  assign lrck_fall = (lrck_sync[1] == LRCK_LEFT)  && (lrck_sync[2] == LRCK_RIGHT);
  assign lrck_rise = (lrck_sync[1] == LRCK_RIGHT) && (lrck_sync[2] == LRCK_LEFT);
  // Data goes through the same depth as BCLK, so this is the level seen at the BCLK rise
  assign dat_bit   = dat_sync[2];

  // Slot 0 after an LRCK edge is the I2S delay slot; slots 1..SB fill the word MSB first
  assign bit_take = (bit_cnt != '0) && (bit_cnt <= CNT_SB);
  assign bit_idx  = IDX_W'(CNT_SB - bit_cnt);

  // Frame alignment, per-channel bit capture and registered frame push
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ALIGN;
      bit_cnt   <= '0;
      left_sr   <= '0;
      right_sr  <= '0;
      left_hold <= '0;
      push_vld  <= 1'b0;
      push_dat  <= '0;
    end else begin
      push_vld <= 1'b0;
      if (!enable) begin
        state    <= ST_ALIGN;
        bit_cnt  <= '0;
        left_sr  <= '0;
        right_sr <= '0;
      end else begin
        case (state)
          ST_ALIGN: begin
            if (lrck_fall) begin
              state   <= ST_LEFT;
              bit_cnt <= '0;
              left_sr <= '0;
            end
          end
          ST_LEFT: begin
            if (lrck_rise) begin
              state     <= ST_RIGHT;
              left_hold <= left_sr;
              bit_cnt   <= '0;
              right_sr  <= '0;
            end else if (bclk_rise) begin
              if (bit_take) left_sr[bit_idx] <= dat_bit;
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ST_RIGHT: begin
            if (lrck_fall) begin
              state    <= ST_LEFT;
              push_vld <= 1'b1;
              push_dat <= {left_hold, right_sr};
              bit_cnt  <= '0;
              left_sr  <= '0;
            end else if (bclk_rise) begin
              if (bit_take) right_sr[bit_idx] <= dat_bit;
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          default: state <= ST_ALIGN;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (2*SAMPLE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (rx.sample_ready),
    .head_dat (rx.sample_data),
    .valid    (rx.sample_valid),
    .dropped  (fifo_drop),
    .level    (rx.fifo_level)
  );

  // Sticky drop flag; a new drop takes priority over a clear in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rx.overflow <= 1'b0;
    end else if (fifo_drop) begin
      rx.overflow <= 1'b1;
    end else if (rx.overflow_clr) begin
      rx.overflow <= 1'b0;
    end
  end

endmodule
